// File: rtl/v_dmem_resp.sv
// Vector LSU memory responder: four word-interleaved banks serving one 4-element
// unit-stride or strided access per request, with bank conflicts serialised.
module v_dmem_resp #(
  parameter int BANK_DEPTH = 1024,
  parameter int ROW_W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_width,
  input  logic [31:0]  req_base,
  input  logic [31:0]  req_stride,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [31:0]  resp_rdata1,
  output logic [31:0]  resp_rdata2,
  output logic [31:0]  resp_rdata3,
  output logic [31:0]  resp_rdata4,
  output logic         busy
);

  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP, ERR} state_t;

  state_t state, state_nxt;

  logic [31:0] addr_c [4];
  logic [3:0]  be_c   [4];
  logic [31:0] wd_c   [4];
  logic [3:0]  mis_c;
  logic        width_ok;
  logic        acc_err;
  logic        accept;
  logic        unused_hi;

  logic [3:0][ROW_W-1:0] row_q;
  logic [3:0][1:0]       ebank_q;
  logic [3:0][3:0]       be_q;
  logic [3:0][31:0]      wd_q;
  logic                  we_q;
  logic [3:0]            pending;
  logic [3:0]            pending_clr;

  logic [3:0]            sel_vld;
  logic [3:0][1:0]       sel_idx;
  logic [3:0][31:0]      bank_rd;
  logic [3:0]            cap_vld;
  logic [3:0][1:0]       cap_idx;
  logic [3:0][31:0]      rdata;

  // Element addresses, alignment and the byte-lane write pattern, all decoded from the live request
  always_comb begin
    width_ok  = (req_width == W8) || (req_width == W16) || (req_width == W32);
    unused_hi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_c[i] = req_base + req_stride * 32'(i);
      mis_c[i]  = 1'b0;
      be_c[i]   = 4'b0000;
      wd_c[i]   = '0;
      unused_hi = unused_hi ^ (^addr_c[i][31:ROW_W+4]);
      case (req_width)
        W8: begin
          be_c[i] = 4'b0001 << addr_c[i][1:0];
          wd_c[i] = {4{req_wdata[32*i +: 8]}};
        end
        W16: begin
          mis_c[i] = addr_c[i][0];
          be_c[i]  = addr_c[i][1] ? 4'b1100 : 4'b0011;
          wd_c[i]  = {2{req_wdata[32*i +: 16]}};
        end
        W32: begin
          mis_c[i] = |addr_c[i][1:0];
          be_c[i]  = 4'b1111;
          wd_c[i]  = req_wdata[32*i +: 32];
        end
        default: ;
      endcase
    end
  end

  assign acc_err = !width_ok || (|mis_c);
  assign accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        row_q[i]   <= addr_c[i][ROW_W+3:4];
        ebank_q[i] <= addr_c[i][3:2];
        be_q[i]    <= be_c[i];
        wd_q[i]    <= wd_c[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      pending <= acc_err ? 4'b0000 : 4'b1111;
      we_q    <= req_we;
    end else if (state == ACCESS) begin
      pending <= pending & ~pending_clr;
    end
  end

  // Per bank, the lowest-index pending element mapped to it wins this cycle
  always_comb begin
    pending_clr = '0;
    sel_vld     = '0;
    sel_idx     = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 3; i >= 0; i--) begin
        if (state == ACCESS && pending[i] && ebank_q[i] == 2'(b)) begin
          sel_vld[b] = 1'b1;
          sel_idx[b] = 2'(i);
        end
      end
      if (sel_vld[b]) pending_clr[sel_idx[b]] = 1'b1;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [31:0]      mem [BANK_DEPTH];
    logic [31:0]      rd;
    logic [ROW_W-1:0] row;
    logic [3:0]       be;
    logic [31:0]      wd;

    assign row = row_q[sel_idx[b]];
    assign be  = be_q[sel_idx[b]];
    assign wd  = wd_q[sel_idx[b]];

    // An element issued in the same cycle as a reset is dropped, earlier ones stay written
    always_ff @(posedge clk) begin
      if (sel_vld[b] && !rst) begin
        if (we_q) begin
          if (be[0]) mem[row][7:0]   <= wd[7:0];
          if (be[1]) mem[row][15:8]  <= wd[15:8];
          if (be[2]) mem[row][23:16] <= wd[23:16];
          if (be[3]) mem[row][31:24] <= wd[31:24];
        end else begin
          rd <= mem[row];
        end
      end
    end

    assign bank_rd[b] = rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld <= '0;
      cap_idx <= '0;
      rdata   <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        cap_vld[b] <= sel_vld[b] && !we_q;
        cap_idx[b] <= sel_idx[b];
      end
      if (accept && acc_err) begin
        rdata <= '0;
      end else begin
        for (int e = 0; e < 4; e++) begin
          for (int b = 0; b < 4; b++) begin
            if (cap_vld[b] && cap_idx[b] == 2'(e)) rdata[e] <= bank_rd[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = acc_err ? ERR : ACCESS;
      ACCESS:  if ((pending & ~pending_clr) == 4'b0000) state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign resp_valid  = (state == RESP) || (state == ERR);
  assign resp_err    = (state == ERR);
  assign resp_rdata1 = rdata[0];
  assign resp_rdata2 = rdata[1];
  assign resp_rdata3 = rdata[2];
  assign resp_rdata4 = rdata[3];

endmodule

// File: tb/tb_v_dmem_resp.sv
// Bench for v_dmem_resp: directed scenarios plus random requests, checked against a
// flat byte-addressed memory model and the bank-count latency rule.
module tb_v_dmem_resp;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_width;
  logic [31:0]  req_base;
  logic [31:0]  req_stride;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_err;
  logic [31:0]  resp_rdata1, resp_rdata2, resp_rdata3, resp_rdata4;
  logic         busy;

  always #5 clk = ~clk;

  v_dmem_resp dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_base(req_base), .req_stride(req_stride),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2),
    .resp_rdata3(resp_rdata3), .resp_rdata4(resp_rdata4),
    .busy(busy)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Physical memory seen as 16 KiB of bytes; addresses wrap at bit 14
  logic [7:0]   mdl [16384];
  logic [127:0] mdlRdata;
  bit           rdataKnown;

  logic [127:0] expRd6;
  int           p1, p2, nPulse;
  bit           readyAt4, noResp;
  logic [2:0]   rw;
  logic [31:0]  rb, rs;
  logic [2:0]   illegal [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

  function automatic logic [127:0] rdataBus();
    return {resp_rdata4, resp_rdata3, resp_rdata2, resp_rdata1};
  endfunction

  function automatic logic [31:0] mdlWord(input logic [31:0] a);
    int w;
    w = int'({a[13:2], 2'b00});
    return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction, starting and ending at a negedge in IDLE
  task automatic applyStimulus(input bit we, input logic [2:0] width, input logic [31:0] base,
                               input logic [31:0] stride, input logic [127:0] wdata,
                               input string tag);
    logic [31:0]  ea [4];
    int           cnt [4];
    bit           err;
    int           k, expLat, lat, idx;
    logic [127:0] expRd;
    logic [31:0]  wd;
    bit           busyOk, readyOk;

    err = !(width == 3'b000 || width == 3'b101 || width == 3'b110);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 4; i++) begin
      ea[i] = base + stride * 32'(i);
      if (width == 3'b101 && ea[i][0]) err = 1'b1;
      if (width == 3'b110 && ea[i][1:0] != 2'b00) err = 1'b1;
      cnt[ea[i][3:2]]++;
    end
    k = 0;
    for (int i = 0; i < 4; i++) if (cnt[i] > k) k = cnt[i];
    expLat = err ? 1 : k + 2;
    if (err)      expRd = '0;
    else if (!we) expRd = {mdlWord(ea[3]), mdlWord(ea[2]), mdlWord(ea[1]), mdlWord(ea[0])};
    else          expRd = mdlRdata;

    checkOutput({tag, "_ready"}, 128'(req_ready), 128'(1));
    req_valid  = 1'b1;
    req_we     = we;
    req_width  = width;
    req_base   = base;
    req_stride = stride;
    req_wdata  = wdata;
    @(negedge clk);
    lat        = 1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_width  = 3'($urandom);
    req_base   = $urandom;
    req_stride = $urandom;
    req_wdata  = {$urandom, $urandom, $urandom, $urandom};
    busyOk  = 1'b1;
    readyOk = 1'b1;
    while (!resp_valid && lat < 20) begin
      if (!busy) busyOk = 1'b0;
      if (req_ready) readyOk = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busyOk = 1'b0;
    if (req_ready) readyOk = 1'b0;
    checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, "_busy"}, 128'(busyOk), 128'(1));
    checkOutput({tag, "_notready"}, 128'(readyOk), 128'(1));
    checkOutput({tag, "_err"}, 128'(resp_err), 128'(err));
    if (!we || err || rdataKnown) checkOutput({tag, "_rdata"}, rdataBus(), expRd);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 128'(resp_valid), 128'(0));
    checkOutput({tag, "_idle"}, 128'(busy), 128'(0));

    if (err) begin
      rdataKnown = 1'b0;
    end else if (!we) begin
      mdlRdata   = expRd;
      rdataKnown = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wd = wdata[32*i +: 32];
        case (width)
          3'b000: begin
            idx = int'(ea[i][13:0]);
            mdl[idx] = wd[7:0];
          end
          3'b101: begin
            idx = int'({ea[i][13:1], 1'b0});
            mdl[idx]   = wd[7:0];
            mdl[idx+1] = wd[15:8];
          end
          default: begin
            idx = int'({ea[i][13:2], 2'b00});
            mdl[idx]   = wd[7:0];
            mdl[idx+1] = wd[15:8];
            mdl[idx+2] = wd[23:16];
            mdl[idx+3] = wd[31:24];
          end
        endcase
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_width  = 3'b000;
    req_base   = '0;
    req_stride = '0;
    req_wdata  = '0;
    for (int i = 0; i < 16384; i++) mdl[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_ready", 128'(req_ready), 128'(1));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_valid", 128'(resp_valid), 128'(0));
    checkOutput("rst_err", 128'(resp_err), 128'(0));
    checkOutput("rst_rdata", rdataBus(), 128'(0));
    mdlRdata   = '0;
    rdataKnown = 1'b1;

    $display("[TB] filling memory with random words");
    for (int n = 0; n < 1024; n++)
      applyStimulus(1'b1, 3'b110, 32'(n * 16), 32'd4, {$urandom, $urandom, $urandom, $urandom}, "init");

    $display("[TB] word store then load, unit stride");
    applyStimulus(1'b1, 3'b110, 32'h100, 32'd4,
                  {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, "t1_st");
    applyStimulus(1'b0, 3'b110, 32'h100, 32'd4, '0, "t1_ld");
    checkOutput("t1_words", rdataBus(), {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});

    $display("[TB] four-way conflict on bank 0");
    applyStimulus(1'b0, 3'b110, 32'h100, 32'd16, '0, "t2_ld");

    $display("[TB] byte store across a word boundary");
    applyStimulus(1'b1, 3'b110, 32'h200, 32'd4,
                  {$urandom, $urandom, 32'hFFFFFFFF, 32'hFFFFFFFF}, "t3_pre");
    applyStimulus(1'b1, 3'b000, 32'h203, 32'd1,
                  {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011}, "t3_st");
    applyStimulus(1'b0, 3'b110, 32'h200, 32'd4, '0, "t3_ld");
    checkOutput("t3_w200", 128'(resp_rdata1), 128'(32'h11FFFFFF));
    checkOutput("t3_w204", 128'(resp_rdata2), 128'(32'hFF443322));

    $display("[TB] misaligned and illegal-width requests");
    applyStimulus(1'b0, 3'b101, 32'h101, 32'd4, '0, "t4_half");
    applyStimulus(1'b0, 3'b011, 32'h100, 32'd4, '0, "t4_ill");
    applyStimulus(1'b1, 3'b110, 32'h102, 32'd4, '0, "t4_stmis");
    applyStimulus(1'b1, 3'b011, 32'h100, 32'd4, '0, "t4_still");
    applyStimulus(1'b0, 3'b110, 32'h100, 32'd4, '0, "t4_ld");
    checkOutput("t4_unchanged", rdataBus(), {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});

    $display("[TB] reset during a conflicted store");
    applyStimulus(1'b1, 3'b110, 32'h100, 32'd16, '0, "t5_pre");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_width  = 3'b110;
    req_base   = 32'h100;
    req_stride = 32'd16;
    req_wdata  = {4{32'h5A5A5A5A}};
    noResp     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (resp_valid) noResp = 1'b0;
    @(negedge clk);
    if (resp_valid) noResp = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    if (resp_valid) noResp = 1'b0;
    checkOutput("t5_busy", 128'(busy), 128'(0));
    checkOutput("t5_rdata", rdataBus(), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) noResp = 1'b0;
    checkOutput("t5_noresp", 128'(noResp), 128'(1));
    checkOutput("t5_ready", 128'(req_ready), 128'(1));
    for (int i = 0; i < 4; i++) mdl[32'h100 + i] = 8'h5A;
    mdlRdata   = '0;
    rdataKnown = 1'b1;
    applyStimulus(1'b0, 3'b110, 32'h100, 32'd16, '0, "t5_ld");
    checkOutput("t5_rows", rdataBus(), {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A});

    $display("[TB] back-to-back loads with valid held");
    expRd6 = {mdlWord(32'h30C), mdlWord(32'h308), mdlWord(32'h304), mdlWord(32'h300)};
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_width  = 3'b110;
    req_base   = 32'h300;
    req_stride = 32'd4;
    p1 = -1;
    p2 = -1;
    nPulse   = 0;
    readyAt4 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) req_valid = 1'b0;
      if (c == 4) readyAt4 = req_ready;
      if (resp_valid) begin
        nPulse++;
        if (p1 < 0) p1 = c;
        else if (p2 < 0) p2 = c;
      end
    end
    checkOutput("t6_first", 128'(p1), 128'(3));
    checkOutput("t6_second", 128'(p2), 128'(7));
    checkOutput("t6_pulses", 128'(nPulse), 128'(2));
    checkOutput("t6_ready4", 128'(readyAt4), 128'(1));
    checkOutput("t6_rdata", rdataBus(), expRd6);
    mdlRdata   = expRd6;
    rdataKnown = 1'b1;

    $display("[TB] random requests");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rw = 3'b000;
        4, 5, 6:    rw = 3'b101;
        7, 8:       rw = 3'b110;
        default:    rw = illegal[$urandom_range(0, 4)];
      endcase
      rb = $urandom;
      case ($urandom_range(0, 5))
        0:       rs = 32'd0;
        1:       rs = 32'd4;
        2:       rs = 32'd16;
        3:       rs = 32'hFFFFFFF0;
        4:       rs = 32'd64;
        default: rs = $urandom;
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (rw == 3'b101) begin
          rb[0] = 1'b0;
          rs[0] = 1'b0;
        end
        if (rw == 3'b110) begin
          rb[1:0] = 2'b00;
          rs[1:0] = 2'b00;
        end
      end
      applyStimulus(1'($urandom), rw, rb, rs, {$urandom, $urandom, $urandom, $urandom}, "rnd");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/v_dmem_resp.md
Name: v_dmem_resp

Overview:
- Memory-side responder for the vector load/store unit. Serves one 4-element vector access per request: unit-stride or strided, load or store, element width 8/16/32.
- Holds four interleaved 32-bit-wide data banks and serialises bank conflicts.
- Loads return the four raw 32-bit words containing the elements. Byte/half extraction stays in the LSU.
- Stores write the low element bits into the addressed byte lanes.

Parameters:
- BANK_DEPTH, 1024: words per bank, power of two.
- ROW_W, 10: log2(BANK_DEPTH).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_width  input  3  000 = 8-bit, 101 = 16-bit, 110 = 32-bit; other codes are illegal
- req_base  input  32  byte address of element 0
- req_stride  input  32  byte stride, two's complement
- req_wdata  input  128  element i in bits [32i+31:32i]
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  qualifies resp_valid: misaligned or illegal width
- resp_rdata1..resp_rdata4  output  32 each  raw word holding element 0..3 (loads only)
- busy  output  1  state != IDLE

Behaviour:
- Reset:
  - State = IDLE; resp_valid = 0, resp_err = 0, rdata = 0, pending mask = 0.
  - req_ready = 1 from the first cycle after rst is deasserted.
  - Bank contents are not cleared.
- Reset mid-operation:
  - Abort with no resp_valid.
  - Stores already issued before the reset edge stay written; unissued elements are dropped.
- Address arithmetic:
  - addr_i = req_base + i*req_stride, mod 2^32.
  - bank = addr_i[3:2]; row = addr_i[ROW_W+3:4] (upper bits ignored, so the array wraps); lane = addr_i[1:0].
- Acceptance: in cycle 0, req_valid & req_ready. All request fields are registered then; later input changes are ignored.
- Alignment check at accept:
  - Error if 16-bit with addr_i[0] = 1, 32-bit with addr_i[1:0] != 0, or width is illegal.
  - Any element failing → state ERR. No bank access.
  - Cycle 1: resp_valid = 1, resp_err = 1, rdata = 0. Cycle 2: IDLE.
- ACCESS state, cycles 1..k:
  - Each cycle, for each bank, issue the lowest-index pending element mapped to that bank, then clear its pending bit.
  - k = max element count on any one bank (1..4). Same-word elements are not merged.
- Read path:
  - Banks have 1-cycle registered read.
  - Each element's word is captured into its own rdata register the cycle after issue.
- Store byte enables:
  - 8-bit: lane only, data = wdata_i[7:0] placed at lane.
  - 16-bit: lanes {addr[1],0} and +1, data = wdata_i[15:0].
  - 32-bit: all lanes.
  - Unenabled bytes are preserved.
- After ACCESS:
  - Cycle k+1: CAPTURE, where the last read data lands.
  - Cycle k+2: RESP, with resp_valid = 1, resp_err = 0 and rdata stable. For stores, rdata holds its previous value.
  - Cycle k+3: IDLE.
- Hold behaviour: rdata holds until the next load's capture. resp_valid is never asserted in two consecutive cycles.
- Back-to-back requests: the next request is accepted no earlier than the IDLE cycle after RESP.
- Read-after-write inside one request cannot occur: it is a load or a store, never both.

Test Plan:
1. Store word, base 0x100, stride 4, wdata {0xDDDDDDDD, 0xCCCCCCCC, 0xBBBBBBBB, 0xAAAAAAAA}; then load the same → each access has k = 1 and resp_valid at cycle 3; load rdata1..4 = 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD.
2. Load word, base 0x100, stride 16 → all four elements hit bank 0, rows 0x10..0x13; ACCESS lasts 4 cycles; resp_valid at cycle 6; busy high in cycles 1..6.
3. Preload words 0x200 and 0x204 with 0xFFFFFFFF. Store byte, base 0x203, stride 1, element low bytes 0x11, 0x22, 0x33, 0x44 → k = 3, because bank 1 holds 3 elements. Word loads then read 0x11FFFFFF at 0x200 and 0xFF443322 at 0x204.
4. Load half at base 0x101, and separately width 011 at any address → resp_valid and resp_err both high in cycle 1, rdata = 0, back in IDLE at cycle 2. A follow-up load shows memory unchanged.
5. Preload the targets with 0. Store word, stride 16, wdata all 0x5A5A5A5A; assert rst in cycle 2 → no resp_valid; req_ready = 1 after release. Row 0x10 reads 0x5A5A5A5A; rows 0x11..0x13 read 0.
6. Hold req_valid high for two loads → second accept occurs in the IDLE cycle after the first RESP; resp_valid pulses are separated by at least 3 cycles.
